// File: rtl/fft_expand.sv
// fft_expand: widens narrow signed complex FFT samples (IN_W bits/component)
// to the wide datapath width (OUT_W bits/component). A per-frame
// block-floating-point exponent is applied as a left shift. Results that do
// not fit in OUT_W bits are clamped, and the clamped samples in each frame
// are counted.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready   input handshake; s_re/s_im signed input components
//   exp_in            frame exponent, sampled when frame index 0 is accepted
//   m_valid/m_ready   output handshake; m_re/m_im signed output components
//   m_last            marks the final sample of a frame
//   ovf_cnt/ovf_vld   clamped-sample count of the last completed frame and
//                     a one-cycle update strobe
module fft_expand #(
   parameter int IN_W      = 11,
   parameter int OUT_W     = 16,
   parameter int FRAME_LEN = 512,
   parameter int SHIFT_W   = 3,
   parameter int CNT_W     = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [IN_W-1:0]    s_re,
   input  logic [IN_W-1:0]    s_im,
   input  logic [SHIFT_W-1:0] exp_in,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [OUT_W-1:0]   m_re,
   output logic [OUT_W-1:0]   m_im,
   output logic               m_last,
   output logic [CNT_W-1:0]   ovf_cnt,
   output logic               ovf_vld
);

   // Wide enough to hold a full-scale input shifted by the largest exponent.
   localparam int EW    = IN_W + 2**SHIFT_W - 1;
   localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic signed [EW-1:0] MAX_V = EW'((2**(OUT_W-1)) - 1);
   localparam logic signed [EW-1:0] MIN_V = -MAX_V - EW'(1);

   // Stage-1 registers
   logic                 v1_q;
   logic signed [EW-1:0] re1_q, im1_q, re1_d, im1_d;
   logic                 last1_q;
   // Stage-2 (output) registers
   logic                 v2_q;
   logic [OUT_W-1:0]     re2_q, im2_q, re2_d, im2_d;
   logic                 last2_q;
   // Frame state
   logic [IDX_W-1:0]     idx_q;
   logic [SHIFT_W-1:0]   exp_q, exp_cur;
   logic [CNT_W-1:0]     acc_q, tot_d, ovf_cnt_q;
   logic                 ovf_vld_q;

   logic adv, acc, ld2, clp_re, clp_im, idx_last;

   // Returns {clamped, value truncated to OUT_W}.
   function automatic logic [OUT_W:0] clamp(input logic signed [EW-1:0] v);
      logic [OUT_W:0] r;
      if (v > MAX_V)      r = {1'b1, MAX_V[OUT_W-1:0]};
      else if (v < MIN_V) r = {1'b1, MIN_V[OUT_W-1:0]};
      else                r = {1'b0, v[OUT_W-1:0]};
      return r;
   endfunction

   always_comb begin
      adv      = ~v2_q | m_ready;
      // Held low for the whole time reset is asserted.
      s_ready  = rst_n & (adv | ~v1_q);
      acc      = s_valid & s_ready;
      ld2      = adv & v1_q;
      idx_last = (idx_q == IDX_W'(FRAME_LEN - 1));

      // The first sample of a frame uses exp_in directly, because the
      // exponent register only takes that value at the same clock edge.
      exp_cur = (idx_q == '0) ? exp_in : exp_q;
      re1_d   = $signed({{(EW-IN_W){s_re[IN_W-1]}}, s_re}) <<< exp_cur;
      im1_d   = $signed({{(EW-IN_W){s_im[IN_W-1]}}, s_im}) <<< exp_cur;

      {clp_re, re2_d} = clamp(re1_q);
      {clp_im, im2_d} = clamp(im1_q);

      // Saturating accumulate. A sample counts once even if both parts clamp.
      tot_d = acc_q;
      if ((clp_re | clp_im) && (acc_q != '1))
         tot_d = acc_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         re1_q     <= '0;
         im1_q     <= '0;
         last1_q   <= 1'b0;
         v2_q      <= 1'b0;
         re2_q     <= '0;
         im2_q     <= '0;
         last2_q   <= 1'b0;
         idx_q     <= '0;
         exp_q     <= '0;
         acc_q     <= '0;
         ovf_cnt_q <= '0;
         ovf_vld_q <= 1'b0;
      end else begin
         ovf_vld_q <= 1'b0;

         if (s_ready) v1_q <= s_valid;
         if (acc) begin
            re1_q   <= re1_d;
            im1_q   <= im1_d;
            last1_q <= idx_last;
            idx_q   <= idx_last ? '0 : idx_q + IDX_W'(1);
            if (idx_q == '0) exp_q <= exp_in;
         end

         // Stage 2 holds its contents while the downstream stalls.
         if (adv) v2_q <= v1_q;
         if (ld2) begin
            re2_q   <= re2_d;
            im2_q   <= im2_d;
            last2_q <= last1_q;
            if (last1_q) begin
               ovf_cnt_q <= tot_d;
               ovf_vld_q <= 1'b1;
               acc_q     <= '0;
            end else begin
               acc_q     <= tot_d;
            end
         end
      end
   end

   assign m_valid = v2_q;
   assign m_re    = re2_q;
   assign m_im    = im2_q;
   assign m_last  = last2_q;
   assign ovf_cnt = ovf_cnt_q;
   assign ovf_vld = ovf_vld_q;

endmodule

// File: tb/tb_fft_expand.sv
// Directed bench for fft_expand with a short frame (FRAME_LEN=4).
module tb_fft_expand;
   localparam int IN_W = 11, OUT_W = 16, FL = 4, SW = 3, CW = 10;

   logic             clk, rst_n, s_valid, s_ready, m_valid, m_ready, m_last, ovf_vld;
   logic [IN_W-1:0]  s_re, s_im;
   logic [SW-1:0]    exp_in;
   logic [OUT_W-1:0] m_re, m_im;
   logic [CW-1:0]    ovf_cnt;

   fft_expand #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(FL), .SHIFT_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_re(s_re), .s_im(s_im), .exp_in(exp_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
      .m_last(m_last), .ovf_cnt(ovf_cnt), .ovf_vld(ovf_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, fails = 0;
   int q_re[$], q_im[$], q_last[$], q_ovf[$], q_ovl[$];
   int sr[4], si[4], er[4], ei[4];

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Output monitor: a beat transfers on the posedge after a negedge that
   // sees m_valid & m_ready.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         q_re.push_back(int'($signed(m_re)));
         q_im.push_back(int'($signed(m_im)));
         q_last.push_back(int'(m_last));
      end
      if (ovf_vld) begin
         q_ovf.push_back(int'(ovf_cnt));
         q_ovl.push_back(int'(m_valid && m_last));
      end
   end

   task automatic clr();
      q_re.delete(); q_im.delete(); q_last.delete(); q_ovf.delete(); q_ovl.delete();
   endtask

   task automatic push(input int re, input int im, input int e);
      bit done;
      done    = 1'b0;
      s_valid = 1'b1;
      s_re    = re[IN_W-1:0];
      s_im    = im[IN_W-1:0];
      exp_in  = e[SW-1:0];
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (s_ready) done = 1'b1;
      end
      if (!done) chk("push_timeout", 0, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   // One frame from sr/si; exponent e0 at index 0, e1 on the other indices.
   task automatic frame(input int e0, input int e1);
      for (int i = 0; i < 4; i++) push(sr[i], si[i], (i == 0) ? e0 : e1);
   endtask

   task automatic drain();
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic chk_frame(input string tag, input int ovf);
      chk({tag, "_nbeats"}, q_re.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < q_re.size()) begin
            chk($sformatf("%s_re%0d", tag, i), q_re[i], er[i]);
            chk($sformatf("%s_im%0d", tag, i), q_im[i], ei[i]);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == 3) ? 1 : 0);
         end
      end
      chk({tag, "_novf"}, q_ovf.size(), 1);
      if (q_ovf.size() > 0) begin
         chk({tag, "_ovfcnt"}, q_ovf[0], ovf);
         chk({tag, "_ovf_on_last"}, q_ovl[0], 1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int na;
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      s_re = '0; s_im = '0; exp_in = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_re", m_re, 0);
      chk("rst_m_im", m_im, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      chk("rst_ovf_vld", ovf_vld, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1);
      @(posedge clk); #1;

      // Test 1: extremes at exp 0, two-register latency
      clr();
      s_valid = 1'b1; s_re = -11'sd1024; s_im = 11'sd1023; exp_in = '0;
      @(negedge clk);
      chk("t1_accept", s_ready, 1);
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk);
      chk("t1_not_yet", m_valid, 0);
      @(negedge clk);
      chk("t1_valid", m_valid, 1);
      chk("t1_re", int'($signed(m_re)), -1024);
      chk("t1_im", int'($signed(m_im)), 1023);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) push(0, 0, 0);
      drain();
      er = '{-1024, 0, 0, 0}; ei = '{1023, 0, 0, 0};
      chk_frame("t1", 0);

      // Test 2: exp 5, exact fit
      clr();
      sr = '{1023, 0, 0, 0}; si = '{-1024, 0, 0, 0};
      frame(5, 5); drain();
      er = '{32736, 0, 0, 0}; ei = '{-32768, 0, 0, 0};
      chk_frame("t2", 0);

      // Test 3: exp 6, clamping both ways, exact -32768 not counted
      clr();
      sr = '{1023, -512, -513, 0}; si = '{0, 0, 0, 0};
      frame(6, 6); drain();
      er = '{32767, -32768, -32768, 0}; ei = '{0, 0, 0, 0};
      chk_frame("t3", 2);

      // Test 4a: exponent latched at index 0, later changes ignored
      clr();
      sr = '{1, 2, -3, 100}; si = '{5, 0, 0, -7};
      frame(6, 0); drain();
      er = '{64, 128, -192, 6400}; ei = '{320, 0, 0, -448};
      chk_frame("t4a", 0);

      // Test 4b: next frame takes new exponent; both parts clamp -> counted once
      clr();
      sr = '{1023, 3, -4, 0}; si = '{-1024, 0, 0, 0};
      frame(7, 0); drain();
      er = '{32767, 384, -512, 0}; ei = '{-32768, 0, 0, 0};
      chk_frame("t4b", 1);

      // Test 6: reset after 2 of 4 samples
      clr();
      push(5, 0, 0);
      push(6, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_m_valid", m_valid, 0);
      chk("t6_ovf_cnt", ovf_cnt, 0);
      chk("t6_s_ready", s_ready, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      clr();
      sr = '{1, 1, 1, 1}; si = '{0, 0, 0, 0};
      frame(2, 0); drain();
      er = '{4, 4, 4, 4}; ei = '{0, 0, 0, 0};
      chk_frame("t6", 0);

      // Test 5: backpressure for 5 clocks with a stream in flight
      clr();
      m_ready = 1'b0;
      sr = '{10, 20, 30, 40}; si = '{-1, -2, -3, -4};
      fork
         frame(1, 1);
         begin
            na = 0;
            for (int k = 1; k <= 5; k++) begin
               @(negedge clk);
               if (s_valid && s_ready) na++;
               if (k == 3) chk("t5_hold_re_k3", int'($signed(m_re)), 20);
            end
            chk("t5_accepts", na, 2);
            chk("t5_s_ready", s_ready, 0);
            chk("t5_m_valid", m_valid, 1);
            chk("t5_hold_re", int'($signed(m_re)), 20);
            chk("t5_hold_im", int'($signed(m_im)), -2);
            @(posedge clk); #1 m_ready = 1'b1;
         end
      join
      drain();
      er = '{20, 40, 60, 80}; ei = '{-2, -4, -6, -8};
      chk_frame("t5", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
